spi_xfer_ctrl: RTL
==================

# spi_xfer_ctrl

Multi-byte SPI transaction sequencer that sits directly upstream of `spi_master`. It buffers outgoing bytes in a TX FIFO and drives the active-low chip select with programmable setup/hold. It feeds bytes to the master one at a time via `start`/`mosi_in`, and collects each received `miso_out` byte into an RX FIFO on `done`. Host logic sees two FIFOs plus a go/busy/done handshake.

## Interface
- `DEPTH`, 8 — entries per FIFO; power of two, ≥2.
- `CS_SETUP`, 4 — clk cycles from `cs_n` falling to first `m_start`; ≥1.
- `CS_HOLD`, 4 — clk cycles from last `m_done` to `cs_n` rising; ≥1.
- `clk` in 1 — single clock for all logic.
- `rst` in 1 — reset, asynchronous, active-low.
- `tx_data` in 8 — byte to enqueue.
- `tx_wr` in 1 — enqueue strobe; accepted only if `tx_full`=0.
- `tx_full` out 1 — TX FIFO holds DEPTH entries.
- `rx_data` out 8 — RX FIFO head; forced 0 while `rx_empty`=1.
- `rx_rd` in 1 — dequeue strobe; ignored if `rx_empty`=1.
- `rx_empty` out 1 — RX FIFO holds no entries.
- `rx_ovf` out 1 — sticky flag: a received byte was dropped because RX was full.
- `xfer_len` in 8 — byte count, sampled on `go`; 0 means 256.
- `go` in 1 — start transaction; honoured only in IDLE.
- `busy` out 1 — high from the cycle after accepted `go` until return to IDLE.
- `xfer_done` out 1 — one-cycle pulse on return to IDLE.
- `cs_n` out 1 — slave select, active-low.
- `m_start` out 1 — to `spi_master.start`; one-cycle pulse.
- `m_data` out 8 — to `spi_master.mosi_in`; registered, held stable until next load.
- `m_done` in 1 — from `spi_master.done`.
- `m_rx` in 8 — from `spi_master.miso_out`; valid while `m_done`=1.

## Operation
- FSM states: IDLE, SETUP, LOAD, WAIT, HOLD.
- IDLE: `cs_n`=1. On `go` → SETUP. Latch remaining count = `xfer_len` (9-bit; 0→256). Clear `rx_ovf`. Load the setup counter.
- SETUP: `cs_n`=0. Stay for CS_SETUP cycles, then → LOAD.
- LOAD: `cs_n`=0.
  - If TX is non-empty: pop the head into `m_data`, pulse `m_start`, → WAIT.
  - If TX is empty: stall in LOAD with `cs_n` held low, no filler byte sent.
- WAIT: on `m_done`:
  - Push `m_rx` into RX if not full; otherwise drop the byte and set `rx_ovf`.
  - Decrement the remaining count. If the count reaches 0 → HOLD, else → LOAD.
- HOLD: `cs_n`=0 for CS_HOLD cycles, then → IDLE. `xfer_done` pulses in the first IDLE cycle.
- `go` while `busy`: ignored, with no effect on `xfer_len` latching.
- FIFOs are circular buffers with log2(DEPTH)-bit pointers that wrap, plus a (log2(DEPTH)+1)-bit level counter. Full means level==DEPTH; empty means level==0.
- TX simultaneous write and pop:
  - When not full: both are performed and the level is unchanged.
  - When full: the write is dropped (`tx_full` governs) and the pop proceeds.
- RX simultaneous `rx_rd` and push:
  - When not full and not empty: both are performed.
  - When full: the push is dropped and `rx_ovf` is set, even though the read frees an entry.
- The host may write TX and read RX at any time, including during a transaction.

## Timing
- Reset (async, `rst`=0) values: `cs_n`=1, `m_start`=0, `m_data`=0x00, `busy`=0, `xfer_done`=0, `tx_full`=0, `rx_empty`=1, `rx_data`=0, `rx_ovf`=0. FSM → IDLE, FIFOs are emptied, counters are cleared.
- Reset mid-transaction: `cs_n` rises asynchronously and the in-flight byte is abandoned. The master is reset by the same `rst` net.
- `go` sampled at edge N: `busy`=1 and `cs_n`=0 from N+1.
- The first `m_start` is high in cycle N+1+CS_SETUP, provided TX is non-empty.
- `m_start` is high exactly one cycle. `m_data` is valid in that same cycle and is held until the next pop.
- Next `m_start` is no earlier than the cycle after `m_done`. This matches the master accepting `start` only in its IDLE state.
- Last `m_done` at edge M: `cs_n`=0 through M+CS_HOLD, `cs_n`=1 at M+CS_HOLD+1. `xfer_done`=1 and `busy`=0 in that same cycle.
- RX byte visible on `rx_data` with `rx_empty`=0 the cycle after the `m_done` push.
- `tx_full`/`rx_empty` update the cycle after the causing write, read, pop or push.

## Test plan
- Loopback, mode 0, `xfer_len`=3, TX preloaded 0xA5,0x3C,0xFF, MISO tied to MOSI:
  - RX pops 0xA5,0x3C,0xFF.
  - `cs_n` low for exactly CS_SETUP+3·byte_time+CS_HOLD cycles.
  - One `xfer_done` pulse.
- Underrun stall, `xfer_len`=2, TX holds only 0x11; write 0x22 after 50 cycles:
  - `cs_n` stays low throughout.
  - Second `m_start` comes the cycle after 0x22 is written.
  - RX receives 2 bytes.
- RX overflow, DEPTH=8, `xfer_len`=10, no `rx_rd`:
  - `rx_ovf`=1 after the 9th byte and RX level stays 8.
  - The next `go` clears `rx_ovf`.
- FIFO boundaries:
  - 9 writes into empty TX: the 9th is dropped and `tx_full`=1 after the 8th.
  - `rx_rd` on empty RX: no change, and `rx_data`=0.
  - Pointer wrap is checked over 20 write/pop cycles.
- `xfer_len`=0 with 256 bytes streamed through TX: exactly 256 `m_start` pulses, then HOLD, then IDLE. A `go` pulsed while `busy` is ignored.
- Assert `rst`=0 during byte 2 of a 4-byte transfer:
  - `cs_n`=1 immediately.
  - All outputs at their reset values.
  - A fresh 1-byte transfer afterwards completes normally.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: multi-byte SPI transaction sequencer placed in front of spi_master.
// Buffers TX/RX bytes in FIFOs, times chip-select setup/hold, and offers a go/busy/done handshake.
module spi_xfer_ctrl #(
  parameter int DEPTH    = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic [7:0] rx_data,
  input  logic       rx_rd,
  output logic       rx_empty,
  output logic       rx_ovf,
  input  logic [7:0] xfer_len,
  input  logic       go,
  output logic       busy,
  output logic       xfer_done,
  output logic       cs_n,
  output logic       m_start,
  output logic [7:0] m_data,
  input  logic       m_done,
  input  logic [7:0] m_rx
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_WAIT, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    rem_q, rem_d;
  logic          ovf_q, ovf_d;
  logic          cs_n_q, busy_q, done_q, m_start_q;
  logic [7:0]    m_data_q;
  logic          tx_pop, rx_got, done_d;

  // TX FIFO
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q;
  logic [LW-1:0] tx_lvl_q;
  logic          tx_empty, tx_push, tx_avail;
  logic [7:0]    tx_head;

  assign tx_empty = (tx_lvl_q == '0);
  assign tx_full  = (tx_lvl_q == LW'(DEPTH));
  assign tx_push  = tx_wr && !tx_full;
  // An empty FIFO passes a same-cycle host write straight through to the master.
  assign tx_avail = !tx_empty || tx_push;
  assign tx_head  = tx_empty ? tx_data : tx_mem[tx_rp_q];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_lvl_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (tx_push && !tx_pop)      tx_lvl_q <= tx_lvl_q + 1'b1;
      else if (!tx_push && tx_pop) tx_lvl_q <= tx_lvl_q - 1'b1;
    end
  end

  // RX FIFO
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_rp_q;
  logic [LW-1:0] rx_lvl_q;
  logic          rx_full, rx_push, rx_pop;

  assign rx_empty = (rx_lvl_q == '0);
  assign rx_full  = (rx_lvl_q == LW'(DEPTH));
  assign rx_push  = rx_got && !rx_full;
  assign rx_pop   = rx_rd && !rx_empty;
  assign rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rp_q];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= m_rx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_lvl_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      if (rx_push && !rx_pop)      rx_lvl_q <= rx_lvl_q + 1'b1;
      else if (!rx_push && rx_pop) rx_lvl_q <= rx_lvl_q - 1'b1;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    tx_pop  = 1'b0;
    rx_got  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_SETUP;
          cnt_d   = CW'(CS_SETUP - 1);
          rem_d   = (xfer_len == 8'd0) ? 9'd256 : {1'b0, xfer_len};
          ovf_d   = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          if (tx_avail) begin
            tx_pop  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LOAD: begin
        if (tx_avail) begin
          tx_pop  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_done) begin
          rx_got = 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == 9'd1) begin
            state_d = S_HOLD;
            cnt_d   = CW'(CS_HOLD - 1);
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A full RX drops the byte even if the host reads in the same cycle.
    if (rx_got && rx_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      ovf_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_data_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      ovf_q     <= ovf_d;
      cs_n_q    <= (state_d == S_IDLE);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
      m_start_q <= tx_pop;
      if (tx_pop) m_data_q <= tx_head;
    end
  end

  assign cs_n      = cs_n_q;
  assign busy      = busy_q;
  assign xfer_done = done_q;
  assign m_start   = m_start_q;
  assign m_data    = m_data_q;
  assign rx_ovf    = ovf_q;

endmodule
